// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned FETCH_PC_W   = 9;
  localparam int unsigned FETCH_INS_W  = 32;
  localparam int unsigned FETCH_PC_INC = 4;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
// Flush wins over push; pop on empty and push on full are ignored.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   do_push, do_pop;

  always_comb begin
    do_push = push && (count_q != CNT_W'(DEPTH));
    do_pop  = pop && (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled IF stage: PC, imem request/kill logic and fetch queue feeding decode.
// Define RISCV_FETCH_BYPASS_EN to present a response on id_* in its arrival cycle.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned    PC_W     = FETCH_PC_W,
  parameter int unsigned    INS_W    = FETCH_INS_W,
  parameter int unsigned    FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    CNT_W    = $clog2(FQ_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INS_W-1:0]   imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INS_W-1:0]   id_instr,
  output logic [CNT_W-1:0]   fq_count,
  output logic               halted
);

  logic [PC_W-1:0]  pc_q, req_pc_q;
  logic             inflight_q, kill_q;
  fetch_entry_t     q_head, resp_entry, shown;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic             resp_ok, bypass, pop, q_push, q_pop, issue;
  logic [CNT_W:0]   occupancy, limit;

  always_comb begin
    resp_entry.pc    = req_pc_q;
    resp_entry.instr = imem_rdata;
    // A response is usable unless reset or a redirect (now or last cycle) killed it.
    resp_ok = inflight_q && !kill_q && !redirect_valid && !reset;
`ifdef RISCV_FETCH_BYPASS_EN
    bypass = q_empty && resp_ok;
`else
    bypass = 1'b0;
`endif
    shown    = bypass ? resp_entry : q_head;
    id_valid = !reset && (!q_empty || bypass);
    id_pc    = id_valid ? shown.pc : '0;
    id_instr = id_valid ? shown.instr : '0;
    pop      = id_valid && id_ready;
    q_pop    = pop && !bypass;
    q_push   = resp_ok && !(bypass && id_ready);

    // Reserve a slot for the in-flight response so the queue cannot overflow.
    occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
    limit     = (CNT_W + 1)'(FQ_DEPTH) + (CNT_W + 1)'(pop);
    issue     = !reset && !halt && !redirect_valid && (occupancy < limit);

    imem_req  = issue;
    imem_addr = pc_q;
    fq_count  = reset ? '0 : q_count;
    halted    = !reset && halt && !inflight_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      kill_q     <= redirect_valid;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q     <= pc_q + PC_W'(FETCH_PC_INC);
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (resp_entry),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule
